// File: rtl/alu_issue_stage.sv
// ID/EX issue register: decodes a MIPS instruction into ALU operands and a control code.
// The decoded entry is registered once behind a valid/ready handshake.
module alu_issue_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           instr,
    input  logic [DATA_W-1:0]     rs_data,
    input  logic [DATA_W-1:0]     rt_data,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_operand0,
    output logic [DATA_W-1:0]     out_operand1,
    output logic [3:0]            out_control,
    output logic                  out_ovf_check,
    output logic [REG_ADDR_W-1:0] out_dest,
    output logic                  out_illegal
);
    localparam logic [3:0] C_AND  = 4'b0000, C_OR   = 4'b0001, C_XOR = 4'b0010, C_NOR = 4'b0011;
    localparam logic [3:0] C_ADDU = 4'b0100, C_ADD  = 4'b0101, C_SUBU = 4'b0110, C_SUB = 4'b0111;
    localparam logic [3:0] C_SLTU = 4'b1000, C_SLL  = 4'b1001, C_SRL = 4'b1010, C_SRA = 4'b1011;

    logic [5:0]  opcode, funct;
    logic [15:0] imm;
    logic [4:0]  shamt;
    logic        unused_rs_idx;

    assign opcode        = instr[31:26];
    assign funct         = instr[5:0];
    assign imm           = instr[15:0];
    assign shamt         = instr[10:6];
    assign unused_rs_idx = ^instr[25:21];

    logic [DATA_W-1:0]     dec_op0, dec_op1, imm_sext, imm_zext;
    logic [3:0]            dec_ctrl;
    logic                  dec_ovf, dec_ill;
    logic [REG_ADDR_W-1:0] dec_dest;

    assign imm_sext = {{(DATA_W-16){imm[15]}}, imm};
    assign imm_zext = {{(DATA_W-16){1'b0}}, imm};

    // Illegal encodings fall through with every payload field forced to zero.
    always_comb begin
        dec_op0  = '0;
        dec_op1  = '0;
        dec_ctrl = C_AND;
        dec_ovf  = 1'b0;
        dec_ill  = 1'b0;
        dec_dest = '0;
        if (opcode == 6'h00) begin
            dec_op0  = rs_data;
            dec_op1  = rt_data;
            dec_dest = REG_ADDR_W'(instr[15:11]);
            case (funct)
                6'h20: begin dec_ctrl = C_ADD; dec_ovf = 1'b1; end
                6'h21: dec_ctrl = C_ADDU;
                6'h22: begin dec_ctrl = C_SUB; dec_ovf = 1'b1; end
                6'h23: dec_ctrl = C_SUBU;
                6'h24: dec_ctrl = C_AND;
                6'h25: dec_ctrl = C_OR;
                6'h26: dec_ctrl = C_XOR;
                6'h27: dec_ctrl = C_NOR;
                6'h2B: dec_ctrl = C_SLTU;
                6'h00, 6'h02, 6'h03: begin
                    dec_op0  = rt_data;
                    dec_op1  = {{(DATA_W-5){1'b0}}, shamt};
                    dec_ctrl = (funct == 6'h00) ? C_SLL : (funct == 6'h02) ? C_SRL : C_SRA;
                end
                6'h04, 6'h06, 6'h07: begin
                    dec_op0  = rt_data;
                    dec_op1  = {{(DATA_W-5){1'b0}}, rs_data[4:0]};
                    dec_ctrl = (funct == 6'h04) ? C_SLL : (funct == 6'h06) ? C_SRL : C_SRA;
                end
                default: dec_ill = 1'b1;
            endcase
        end else begin
            dec_op0  = rs_data;
            dec_dest = REG_ADDR_W'(instr[20:16]);
            case (opcode)
                6'h08: begin dec_ctrl = C_ADD; dec_ovf = 1'b1; dec_op1 = imm_sext; end
                6'h09: begin dec_ctrl = C_ADDU; dec_op1 = imm_sext; end
                6'h0B: begin dec_ctrl = C_SLTU; dec_op1 = imm_sext; end
                6'h0C: begin dec_ctrl = C_AND; dec_op1 = imm_zext; end
                6'h0D: begin dec_ctrl = C_OR;  dec_op1 = imm_zext; end
                6'h0E: begin dec_ctrl = C_XOR; dec_op1 = imm_zext; end
                6'h0F: begin dec_ctrl = C_SLL; dec_op0 = imm_zext; dec_op1 = DATA_W'(16); end
                default: dec_ill = 1'b1;
            endcase
        end
        if (dec_ill) begin
            dec_op0  = '0;
            dec_op1  = '0;
            dec_ctrl = C_AND;
            dec_ovf  = 1'b0;
            dec_dest = '0;
        end
    end

    logic valid_q, valid_d, load;

    assign in_ready = !valid_q || out_ready;
    assign load     = in_valid && in_ready && !flush;

    always_comb begin
        valid_d = valid_q;
        if (flush)          valid_d = 1'b0;
        else if (load)      valid_d = 1'b1;
        else if (out_ready) valid_d = 1'b0;
    end

    logic [DATA_W-1:0]     op0_q, op1_q;
    logic [3:0]            ctrl_q;
    logic                  ovf_q, ill_q;
    logic [REG_ADDR_W-1:0] dest_q;

    // Payload only captures on a load so a stalled entry stays bit-stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            op0_q   <= '0;
            op1_q   <= '0;
            ctrl_q  <= '0;
            ovf_q   <= 1'b0;
            ill_q   <= 1'b0;
            dest_q  <= '0;
        end else begin
            valid_q <= valid_d;
            if (load) begin
                op0_q  <= dec_op0;
                op1_q  <= dec_op1;
                ctrl_q <= dec_ctrl;
                ovf_q  <= dec_ovf;
                ill_q  <= dec_ill;
                dest_q <= dec_dest;
            end
        end
    end

    assign out_valid     = valid_q;
    assign out_operand0  = op0_q;
    assign out_operand1  = op1_q;
    assign out_control   = ctrl_q;
    assign out_ovf_check = ovf_q;
    assign out_dest      = dest_q;
    assign out_illegal   = ill_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed steps then random traffic against a table-style reference model.
module tb_alu_issue_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, in_ready, flush = 1'b0, out_valid, out_ready = 1'b1;
    logic [31:0] instr = '0, rs_data = '0, rt_data = '0;
    logic [31:0] out_operand0, out_operand1;
    logic [3:0]  out_control;
    logic        out_ovf_check, out_illegal;
    logic [4:0]  out_dest;

    int errors = 0;
    int checks = 0;

    alu_issue_stage #(.DATA_W(32), .REG_ADDR_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .rs_data(rs_data), .rt_data(rt_data), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_operand0(out_operand0), .out_operand1(out_operand1),
        .out_control(out_control), .out_ovf_check(out_ovf_check),
        .out_dest(out_dest), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] op0;
        logic [31:0] op1;
        logic [3:0]  ctrl;
        logic        ovf;
        logic [4:0]  dest;
        logic        ill;
    } ent_t;

    ent_t m_ent;
    logic m_valid;

    // Reference decode from the mnemonic groups; codes are derived arithmetically per group.
    function automatic ent_t ref_decode(logic [31:0] ins, logic [31:0] rs, logic [31:0] rt);
        ent_t e;
        int   op, f;
        bit   legal;
        e = '0;
        op = int'(ins[31:26]);
        f = int'(ins[5:0]);
        legal = 1'b1;
        if (op == 0) begin
            e.dest = ins[15:11];
            if (f >= 32 && f <= 35) begin
                e.ctrl = 4'(4 + 2 * (f >= 34 ? 1 : 0) + (f % 2 == 0 ? 1 : 0));
                e.ovf = (f % 2 == 0);
                e.op0 = rs; e.op1 = rt;
            end else if (f >= 36 && f <= 39) begin
                e.ctrl = 4'(f - 36); e.op0 = rs; e.op1 = rt;
            end else if (f == 43) begin
                e.ctrl = 4'd8; e.op0 = rs; e.op1 = rt;
            end else if (f == 0 || f == 2 || f == 3) begin
                e.ctrl = 4'(f == 0 ? 9 : 8 + f); e.op0 = rt; e.op1 = 32'(ins[10:6]);
            end else if (f == 4 || f == 6 || f == 7) begin
                e.ctrl = 4'(f == 4 ? 9 : f + 4); e.op0 = rt; e.op1 = rs % 32;
            end else legal = 1'b0;
        end else begin
            e.dest = ins[20:16];
            e.op0 = rs;
            if (op == 8 || op == 9 || op == 11) begin
                e.ctrl = 4'(op == 8 ? 5 : (op == 9 ? 4 : 8));
                e.ovf = (op == 8);
                e.op1 = {{16{ins[15]}}, ins[15:0]};
            end else if (op >= 12 && op <= 14) begin
                e.ctrl = 4'(op - 12); e.op1 = 32'(ins[15:0]);
            end else if (op == 15) begin
                e.ctrl = 4'd9; e.op0 = 32'(ins[15:0]); e.op1 = 32'd16;
            end else legal = 1'b0;
        end
        if (!legal) begin
            e = '0;
            e.ill = 1'b1;
        end
        return e;
    endfunction

    function automatic logic [31:0] r_ins(int rs, int rt, int rd, int sh, int fn);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
    endfunction

    function automatic logic [31:0] i_ins(int op, int rs, int rt, int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(string tag);
        chk({tag, ".valid"}, 32'(out_valid), 32'(m_valid));
        chk({tag, ".op0"}, out_operand0, m_ent.op0);
        chk({tag, ".op1"}, out_operand1, m_ent.op1);
        chk({tag, ".ctrl"}, 32'(out_control), 32'(m_ent.ctrl));
        chk({tag, ".ovf"}, 32'(out_ovf_check), 32'(m_ent.ovf));
        chk({tag, ".dest"}, 32'(out_dest), 32'(m_ent.dest));
        chk({tag, ".ill"}, 32'(out_illegal), 32'(m_ent.ill));
    endtask

    // One clock: drive, check in_ready, advance model across the edge, check outputs.
    task automatic cycle(string tag, logic iv, logic [31:0] ins, logic [31:0] rs, logic [31:0] rt,
                         logic fl, logic ordy);
        logic exp_ready;
        in_valid = iv; instr = ins; rs_data = rs; rt_data = rt; flush = fl; out_ready = ordy;
        #1;
        exp_ready = !m_valid || ordy;
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(exp_ready));
        @(posedge clk);
        if (fl) m_valid = 1'b0;
        else if (iv && exp_ready) begin
            m_valid = 1'b1;
            m_ent = ref_decode(ins, rs, rt);
        end else if (ordy) m_valid = 1'b0;
        #1;
        chk_all(tag);
    endtask

    initial begin
        logic [31:0] held_op0;
        logic [31:0] legal_r [15];
        logic [5:0]  legal_i [7];
        legal_r = '{32'h20, 32'h21, 32'h22, 32'h23, 32'h24, 32'h25, 32'h26, 32'h27,
                    32'h2B, 32'h00, 32'h02, 32'h03, 32'h04, 32'h06, 32'h07};
        legal_i = '{6'h08, 6'h09, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F};
        m_valid = 1'b0;
        m_ent = '0;

        @(posedge clk); @(posedge clk); #1;
        chk_all("reset");
        chk("reset.in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;

        cycle("add", 1, 32'h00221820, 32'h7FFFFFFF, 32'h1, 0, 1);
        chk("add.ctrl_lit", 32'(out_control), 32'h5);
        chk("add.ovf_lit", 32'(out_ovf_check), 32'h1);
        chk("add.dest_lit", 32'(out_dest), 32'd3);
        cycle("addiu", 1, 32'h2485FFFF, 32'h10, 32'h0, 0, 1);
        chk("addiu.op1_lit", out_operand1, 32'hFFFFFFFF);
        chk("addiu.ctrl_lit", 32'(out_control), 32'h4);
        cycle("ori", 1, i_ins(13, 4, 5, 16'hFFFF), 32'h5, 32'h0, 0, 1);
        chk("ori.op1_lit", out_operand1, 32'h0000FFFF);
        cycle("lui", 1, i_ins(15, 0, 6, 16'h1234), 32'h99, 32'h0, 0, 1);
        chk("lui.op0_lit", out_operand0, 32'h00001234);
        chk("lui.op1_lit", out_operand1, 32'd16);
        chk("lui.ctrl_lit", 32'(out_control), 32'h9);
        cycle("sra", 1, 32'h00071103, 32'h0, 32'h80000000, 0, 1);
        chk("sra.ctrl_lit", 32'(out_control), 32'hB);
        chk("sra.op1_lit", out_operand1, 32'd4);
        cycle("srlv", 1, r_ins(1, 2, 3, 0, 6), 32'h00000123, 32'hABCD0000, 0, 1);
        chk("srlv.op1_lit", out_operand1, 32'd3);
        cycle("slt", 1, 32'h0022182A, 32'h5, 32'h6, 0, 1);
        chk("slt.ill_lit", 32'(out_illegal), 32'd1);
        cycle("op3f", 1, 32'hFC221820, 32'h5, 32'h6, 0, 1);
        chk("op3f.op0_lit", out_operand0, 32'd0);

        cycle("bp_load", 1, r_ins(1, 2, 7, 0, 32'h25), 32'h0F0F0000, 32'h000000F0, 0, 1);
        held_op0 = out_operand0;
        for (int i = 0; i < 3; i++) begin
            cycle("bp_stall", 1, r_ins(3, 4, 8, 0, 32'h21), 32'h1111 * (i + 1), 32'h2, 0, 0);
            chk("bp_stall.frozen", out_operand0, held_op0);
        end
        for (int i = 0; i < 4; i++)
            cycle("b2b", 1, r_ins(i, i + 1, i + 2, 0, 32'h23), 32'h100 + i, 32'h10 * i, 0, 1);
        cycle("flush", 1, r_ins(1, 2, 3, 0, 32'h20), 32'h1, 32'h2, 1, 1);
        chk("flush.valid_lit", 32'(out_valid), 32'd0);
        cycle("drain", 0, 32'h0, 32'h0, 32'h0, 0, 1);

        cycle("pre_rst", 1, 32'h00221820, 32'h12345678, 32'h9, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        m_valid = 1'b0;
        m_ent = '0;
        chk_all("async_rst");
        chk("async_rst.in_ready", 32'(in_ready), 32'd1);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 400; i++) begin
            logic [31:0] ins;
            int pick;
            pick = int'($urandom_range(0, 9));
            if (pick < 5)
                ins = {6'd0, 20'($urandom), 6'(legal_r[$urandom_range(0, 14)])};
            else if (pick < 9)
                ins = {legal_i[$urandom_range(0, 6)], 26'($urandom)};
            else
                ins = $urandom;
            cycle("rand", 1'($urandom_range(0, 3) != 0), ins, $urandom, $urandom,
                  1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 3) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
